// File: rtl/decode_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
//   Shared types, constants and decode helpers for the instruction-decode stage.
//   Contents:
//     fwd_src_t   - one forwarding source {write_enable, dest_addr, data, data_ready}
//     if_id_t     - packet arriving from fetch
//     id_ex_t     - decoded packet handed to execute
//     csr_pack_t  - snapshot of the CSRs readable by decode
//     op_e        - decoded operation class
//     decode_op / decode_imm / csr_select - instruction, immediate and CSR parse
//     src_used    - which source operands an op actually reads
// -----------------------------------------------------------------------------
package decode_pkg;

  localparam int RS3_LSB     = 27;
  localparam int NUM_FWD_MAX = 4;

  typedef struct packed {
    logic        write_enable;
    logic [4:0]  dest_addr;
    logic [63:0] data;
    logic        data_ready;
  } fwd_src_t;

  typedef enum logic [3:0] {
    OP_ILLEGAL = 4'd0,
    OP_LUI     = 4'd1,
    OP_AUIPC   = 4'd2,
    OP_JAL     = 4'd3,
    OP_JALR    = 4'd4,
    OP_BRANCH  = 4'd5,
    OP_LOAD    = 4'd6,
    OP_STORE   = 4'd7,
    OP_ALU_IMM = 4'd8,
    OP_ALU_REG = 4'd9,
    OP_CSR     = 4'd10,
    OP_MADD    = 4'd11
  } op_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
    logic        valid;
    logic [63:0] inst_counter;
  } if_id_t;

  typedef struct packed {
    logic [63:0] mstatus;
    logic [63:0] mtvec;
    logic [63:0] mscratch;
    logic [63:0] mepc;
    logic [63:0] mcause;
  } csr_pack_t;

  typedef struct packed {
    op_e         op;
    logic [63:0] immed;
    logic [4:0]  reg1_addr;
    logic [63:0] reg1_value;
    logic [4:0]  reg2_addr;
    logic [63:0] reg2_value;
    logic [4:0]  reg3_addr;
    logic [63:0] reg3_value;
    logic [63:0] csr_value;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        valid;
    logic [63:0] inst_counter;
  } id_ex_t;

  // Major-opcode classification (RV64-style encoding, inst[6:0]).
  function automatic op_e decode_op(input logic [31:0] inst);
    op_e op;
    case (inst[6:0])
      7'b0110111: op = OP_LUI;
      7'b0010111: op = OP_AUIPC;
      7'b1101111: op = OP_JAL;
      7'b1100111: op = OP_JALR;
      7'b1100011: op = OP_BRANCH;
      7'b0000011: op = OP_LOAD;
      7'b0100011: op = OP_STORE;
      7'b0010011: op = OP_ALU_IMM;
      7'b0110011: op = OP_ALU_REG;
      7'b1000011: op = OP_MADD;
      // funct3 == 0 on SYSTEM is ecall/ebreak, which decode treats as illegal.
      7'b1110011: op = (inst[14:12] != 3'b000) ? OP_CSR : OP_ILLEGAL;
      default:    op = OP_ILLEGAL;
    endcase
    return op;
  endfunction

  // Sign-extended immediate for each format; CSR ops carry the 5-bit uimm.
  function automatic logic [63:0] decode_imm(input op_e op, input logic [31:0] inst);
    logic [63:0] imm;
    case (op)
      OP_LUI, OP_AUIPC:
        imm = {{32{inst[31]}}, inst[31:12], 12'b0};
      OP_JAL:
        imm = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      OP_JALR, OP_LOAD, OP_ALU_IMM:
        imm = {{52{inst[31]}}, inst[31:20]};
      OP_STORE:
        imm = {{52{inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRANCH:
        imm = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OP_CSR:
        imm = {59'b0, inst[19:15]};
      default:
        imm = '0;
    endcase
    return imm;
  endfunction

  // CSR read selector; unknown addresses and non-CSR ops read as zero.
  function automatic logic [63:0] csr_select(input op_e op, input logic [11:0] addr,
                                             input csr_pack_t csrs);
    logic [63:0] val;
    val = '0;
    if (op == OP_CSR) begin
      case (addr)
        12'h300: val = csrs.mstatus;
        12'h305: val = csrs.mtvec;
        12'h340: val = csrs.mscratch;
        12'h341: val = csrs.mepc;
        12'h342: val = csrs.mcause;
        default: val = '0;
      endcase
    end
    return val;
  endfunction

  // True when op reads source s (0 = rs1, 1 = rs2, 2 = rs3). Only used
  // operands may raise a load-use hazard.
  function automatic logic src_used(input op_e op, input int s);
    logic used;
    case (s)
      0: used = op inside {OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE,
                           OP_ALU_IMM, OP_ALU_REG, OP_CSR, OP_MADD};
      1: used = op inside {OP_BRANCH, OP_STORE, OP_ALU_REG, OP_MADD};
      2: used = (op == OP_MADD);
      default: used = 1'b0;
    endcase
    return used;
  endfunction

endpackage

// File: rtl/decode_stage_operand_forward.sv
// -----------------------------------------------------------------------------
// operand_forward
//   Resolves one source operand: x0 reads zero, otherwise the youngest
//   (lowest-index) matching forwarding source wins, otherwise the register file.
//   Ports:
//     addr          in   5        source register address
//     fwd           in   NUM_FWD  forwarding sources, index 0 youngest
//     regs_value    in   32 x 64  architectural register file
//     value         out  64       resolved operand value
//     hit_not_ready out  1        the selected forwarding source has no data yet
// -----------------------------------------------------------------------------
module operand_forward
  import decode_pkg::*;
#(
  parameter int NUM_FWD = 3
) (
  input  logic [4:0]  addr,
  input  fwd_src_t    fwd [NUM_FWD],
  input  logic [63:0] regs_value [32],
  output logic [63:0] value,
  output logic        hit_not_ready
);

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, so no path leaves it unassigned (no latch).
  always_comb begin
    logic found;
    found         = 1'b0;
    value         = regs_value[addr];
    hit_not_ready = 1'b0;
    if (addr == 5'd0) begin
      value = '0;
    end else begin
      // First match in index order wins; a ready match further down the list
      // never overrides a not-ready younger producer.
      for (int i = 0; i < NUM_FWD; i++) begin
        if (!found && fwd[i].write_enable && fwd[i].dest_addr == addr &&
            fwd[i].dest_addr != 5'd0) begin
          found         = 1'b1;
          value         = fwd[i].data;
          hit_not_ready = !fwd[i].data_ready;
        end
      end
    end
  end

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//   Registered instruction-decode stage between the if_id and id_ex boundaries.
//   Resolves NUM_SRC operands through operand_forward, stalls on load-use
//   hazards, and holds the decoded packet behind a valid/ready handshake.
//   Optional feature macro: DECODE_STALL_CNT_EN adds a saturating 32-bit
//   stall_cycles counter and its output port.
//   Ports:
//     clk, reset     in   1            clock, synchronous active-high reset
//     flush          in   1            squash held and incoming packet
//     in_valid       in   1            if_id packet offered
//     in_ready       out  1            packet accepted this cycle
//     in_pkt         in   if_id_t      fetched instruction
//     fwd            in   NUM_FWD      forwarding sources (index 0 youngest)
//     regs_value     in   32 x 64      register file
//     csr_values     in   csr_pack_t   CSR snapshot
//     out_valid      out  1            output register holds a packet
//     out_ready      in   1            execute consumes the packet
//     out_pkt        out  id_ex_t      decoded packet
//     stall_cycles   out  32           (DECODE_STALL_CNT_EN only)
//   Parameters: NUM_FWD 1..4, NUM_SRC 2 or 3 (3 adds rs3 = inst[31:27]).
// -----------------------------------------------------------------------------
module decode_stage
  import decode_pkg::*;
#(
  parameter int NUM_FWD = 3,
  parameter int NUM_SRC = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  if_id_t      in_pkt,
  input  fwd_src_t    fwd [NUM_FWD],
  input  logic [63:0] regs_value [32],
  input  csr_pack_t   csr_values,
  output logic        out_valid,
  input  logic        out_ready,
  output id_ex_t      out_pkt
`ifdef DECODE_STALL_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  // Decode of the incoming instruction.
  op_e         dec_op;
  logic [63:0] dec_imm;
  logic [63:0] dec_csr;

  assign dec_op  = decode_op(in_pkt.inst);
  assign dec_imm = decode_imm(dec_op, in_pkt.inst);
  assign dec_csr = csr_select(dec_op, in_pkt.inst[31:20], csr_values);

  // Operand resolution; slot 2 exists only when NUM_SRC == 3.
  logic [4:0]  src_addr      [3];
  logic [63:0] src_value     [3];
  logic        src_hit_nrdy  [3];

  assign src_addr[0] = in_pkt.inst[19:15];
  assign src_addr[1] = in_pkt.inst[24:20];
  assign src_addr[2] = (NUM_SRC == 3) ? in_pkt.inst[RS3_LSB +: 5] : 5'd0;

  for (genvar s = 0; s < 3; s++) begin : g_src
    if (s < NUM_SRC) begin : g_fwd
      operand_forward #(
        .NUM_FWD (NUM_FWD)
      ) u_operand_forward (
        .addr          (src_addr[s]),
        .fwd           (fwd),
        .regs_value    (regs_value),
        .value         (src_value[s]),
        .hit_not_ready (src_hit_nrdy[s])
      );
    end else begin : g_none
      assign src_value[s]    = '0;
      assign src_hit_nrdy[s] = 1'b0;
    end
  end

  // Load-use hazard: only operands the op really reads can stall.
  logic hazard;

  always_comb begin
    hazard = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (src_used(dec_op, s) && src_hit_nrdy[s]) hazard = 1'b1;
    end
  end

  // Handshake. reset is folded in so nothing is offered as accepted while the
  // stage is being cleared.
  logic load;

  assign in_ready = !reset && !flush && !hazard && (!out_valid || out_ready);
  assign load     = in_valid && in_ready;

  // Packet captured on load.
  id_ex_t next_pkt;

  always_comb begin
    next_pkt              = '0;
    next_pkt.op           = dec_op;
    next_pkt.immed        = dec_imm;
    next_pkt.reg1_addr    = src_addr[0];
    next_pkt.reg1_value   = src_value[0];
    next_pkt.reg2_addr    = src_addr[1];
    next_pkt.reg2_value   = src_value[1];
    next_pkt.reg3_addr    = src_addr[2];
    next_pkt.reg3_value   = src_value[2];
    next_pkt.csr_value    = dec_csr;
    next_pkt.inst         = in_pkt.inst;
    next_pkt.inst_pc      = in_pkt.pc;
    next_pkt.valid        = in_pkt.valid;
    next_pkt.inst_counter = in_pkt.inst_counter;
  end

  // Output register. Flush only clears out_valid; the stale payload is
  // invisible without it and is overwritten by the next load.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_pkt   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_pkt   <= next_pkt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef DECODE_STALL_CNT_EN
  // Counts cycles in which an offered packet is held back by a hazard.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (in_valid && hazard && !flush && stall_cycles != 32'hFFFF_FFFF) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule
